button_conditioner: RTL and testbench

- Cleans one raw pushbutton pin into a stable level and single-cycle event pulses.
- Sits directly upstream of ledsweep.
  - btn_press drives the sweep's synchronous rst.
  - btn_short and btn_long are available for sweep mode/pause control.
- Contents: input synchronizer, debounce counter, and a press-classification state machine (short vs long press).

---
 rtl/button_conditioner.sv | 118 +++++++++++
 tb/tb_button_conditioner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Pushbutton conditioner: synchronizer, debounce counter and a short/long press classifier.
// Every output is registered so downstream logic sees clean single-cycle pulses.
module button_conditioner #(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned DEBOUNCE_LEN = 20,
   parameter int unsigned LONG_LEN     = 25,
   parameter int unsigned ACTIVE_LOW   = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_short,
   output logic btn_long,
   output logic btn_held
);

   localparam logic Inactive = logic'(ACTIVE_LOW != 0);
   localparam logic [DEBOUNCE_LEN-1:0] DebOne = 1;
   localparam logic [LONG_LEN-1:0] LongOne = 1;

   typedef enum logic [1:0] {StIdle, StPressed, StHeld} state_e;

   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    sample;
   logic [DEBOUNCE_LEN-1:0] deb_cnt_q, deb_cnt_d;
   logic                    stable_q, stable_d;
   logic                    rise, fall;
   state_e                  state_q, state_d;
   logic [LONG_LEN-1:0]     long_cnt_q, long_cnt_d;
   logic                    press_q, release_q, short_q, long_q;
   logic                    short_d, long_d;

   // The last synchronizer stage, normalised so that 1 always means pressed
   assign sample = sync_q[SYNC_STAGES-1] ^ Inactive;

   always_comb begin
      stable_d  = stable_q;
      deb_cnt_d = '0;
      if (sample != stable_q) begin
         if (deb_cnt_q == '1) begin
            stable_d = ~stable_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DebOne;
         end
      end
   end

   assign rise = stable_d & ~stable_q;
   assign fall = ~stable_d & stable_q;

   always_comb begin
      state_d    = state_q;
      long_cnt_d = long_cnt_q;
      short_d    = 1'b0;
      long_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            long_cnt_d = '0;
            if (rise) state_d = StPressed;
         end
         StPressed: begin
            // A release on the threshold cycle still counts as a short press
            if (fall) begin
               state_d    = StIdle;
               short_d    = 1'b1;
               long_cnt_d = '0;
            end else if (long_cnt_q == '1) begin
               state_d = StHeld;
               long_d  = 1'b1;
            end else begin
               long_cnt_d = long_cnt_q + LongOne;
            end
         end
         StHeld: begin
            if (fall) begin
               state_d    = StIdle;
               long_cnt_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= {SYNC_STAGES{Inactive}};
         deb_cnt_q  <= '0;
         stable_q   <= 1'b0;
         state_q    <= StIdle;
         long_cnt_q <= '0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         short_q    <= 1'b0;
         long_q     <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], btn_in};
         deb_cnt_q  <= deb_cnt_d;
         stable_q   <= stable_d;
         state_q    <= state_d;
         long_cnt_q <= long_cnt_d;
         press_q    <= rise;
         release_q  <= fall;
         short_q    <= short_d;
         long_q     <= long_d;
      end
   end

   assign btn_level   = stable_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign btn_short   = short_q;
   assign btn_long    = long_q;
   assign btn_held    = (state_q == StHeld);

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: segment table, exact-latency sequences and random bursts,
// all checked cycle by cycle against a run-length reference model.
module tb_button_conditioner;

   localparam int unsigned SYNC = 2;
   localparam int unsigned DEB  = 3;
   localparam int unsigned LONG = 5;
   localparam int unsigned AL   = 1;
   localparam int DebN  = 8;
   localparam int LongN = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_in = 1'b1;
   logic btn_level, btn_press, btn_release, btn_short, btn_long, btn_held;

   int n_cmp = 0;
   int n_bad = 0;

   button_conditioner #(
      .SYNC_STAGES (SYNC),
      .DEBOUNCE_LEN(DEB),
      .LONG_LEN    (LONG),
      .ACTIVE_LOW  (AL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .btn_short  (btn_short),
      .btn_long   (btn_long),
      .btn_held   (btn_held)
   );

   always #5 clk = ~clk;

   // Reference model: pin history, run length of disagreeing samples, age since press
   bit m_hist[SYNC];
   bit m_level, m_in_press, m_held;
   int m_run, m_age;
   bit e_press, e_release, e_short, e_long;

   int c_press, c_release, c_short, c_long;

   function automatic void check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic m_step(input logic r, input logic pin);
      bit s, prev;
      e_press = 0; e_release = 0; e_short = 0; e_long = 0;
      if (r) begin
         for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
         m_level = 0; m_run = 0; m_in_press = 0; m_held = 0; m_age = 0;
         return;
      end
      s = m_hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = (AL != 0) ? !pin : pin;
      prev = m_level;
      if (s != m_level) begin
         m_run++;
         if (m_run == DebN) begin
            m_level = !m_level;
            m_run = 0;
         end
      end else begin
         m_run = 0;
      end
      e_press   = m_level && !prev;
      e_release = !m_level && prev;
      if (e_press) begin
         m_in_press = 1; m_held = 0; m_age = 0;
      end else if (e_release) begin
         e_short = m_in_press && !m_held;
         m_in_press = 0; m_held = 0;
      end else if (m_in_press && !m_held) begin
         m_age++;
         if (m_age == LongN) begin
            e_long = 1; m_held = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      m_step(rst, btn_in);
      #1;
      check("level", btn_level, m_level);
      check("press", btn_press, e_press);
      check("release", btn_release, e_release);
      check("short", btn_short, e_short);
      check("long", btn_long, e_long);
      check("held", btn_held, m_held);
      c_press   += int'(btn_press);
      c_release += int'(btn_release);
      c_short   += int'(btn_short);
      c_long    += int'(btn_long);
   endtask

   typedef struct {
      bit rst;
      bit pin;
      int cycles;
      int presses;
      int releases;
      int shorts;
      int longs;
      bit level;
      bit held;
   } seg_t;

   seg_t segs[16];

   initial begin
      int lat, cnt, rel_cnt;
      logic hd, sh, seen;

      //         rst   pin   cyc pr rl sh lg lvl   held
      segs[0]  = '{1'b1, 1'b1, 3,   0, 0, 0, 0, 1'b0, 1'b0};
      segs[1]  = '{1'b0, 1'b1, 50,  0, 0, 0, 0, 1'b0, 1'b0};
      segs[2]  = '{1'b0, 1'b0, 7,   0, 0, 0, 0, 1'b0, 1'b0};
      segs[3]  = '{1'b0, 1'b1, 1,   0, 0, 0, 0, 1'b0, 1'b0};
      segs[4]  = '{1'b0, 1'b0, 7,   0, 0, 0, 0, 1'b0, 1'b0};
      segs[5]  = '{1'b0, 1'b1, 1,   0, 0, 0, 0, 1'b0, 1'b0};
      segs[6]  = '{1'b0, 1'b0, 7,   0, 0, 0, 0, 1'b0, 1'b0};
      segs[7]  = '{1'b0, 1'b1, 20,  0, 0, 0, 0, 1'b0, 1'b0};
      segs[8]  = '{1'b0, 1'b0, 25,  1, 0, 0, 0, 1'b1, 1'b0};
      segs[9]  = '{1'b0, 1'b1, 20,  0, 1, 1, 0, 1'b0, 1'b0};
      segs[10] = '{1'b0, 1'b0, 150, 1, 0, 0, 1, 1'b1, 1'b1};
      segs[11] = '{1'b0, 1'b1, 20,  0, 1, 0, 0, 1'b0, 1'b0};
      segs[12] = '{1'b0, 1'b0, 15,  1, 0, 0, 0, 1'b1, 1'b0};
      segs[13] = '{1'b1, 1'b0, 2,   0, 0, 0, 0, 1'b0, 1'b0};
      segs[14] = '{1'b0, 1'b0, 20,  1, 0, 0, 0, 1'b1, 1'b0};
      segs[15] = '{1'b0, 1'b1, 20,  0, 1, 1, 0, 1'b0, 1'b0};

      for (int s = 0; s < 16; s++) begin
         c_press = 0; c_release = 0; c_short = 0; c_long = 0;
         rst = segs[s].rst;
         btn_in = segs[s].pin;
         for (int k = 0; k < segs[s].cycles; k++) tick();
         check_int($sformatf("seg%0d presses", s), c_press, segs[s].presses);
         check_int($sformatf("seg%0d releases", s), c_release, segs[s].releases);
         check_int($sformatf("seg%0d shorts", s), c_short, segs[s].shorts);
         check_int($sformatf("seg%0d longs", s), c_long, segs[s].longs);
         check($sformatf("seg%0d end level", s), btn_level, segs[s].level);
         check($sformatf("seg%0d end held", s), btn_held, segs[s].held);
      end

      // Exact press and long-press latencies, then no repeat and a clean release
      rst = 1'b0; btn_in = 1'b1;
      repeat (20) tick();
      btn_in = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (btn_press) begin lat = i; break; end
      end
      check_int("press latency", lat, SYNC + DebN);
      check("level at press", btn_level, 1'b1);
      lat = -1; hd = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (btn_long) begin lat = i; hd = btn_held; break; end
      end
      check_int("long latency", lat, LongN);
      check("held with long", hd, 1'b1);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         cnt += int'(btn_long);
      end
      check_int("repeat long", cnt, 0);
      btn_in = 1'b1;
      seen = 1'b0; sh = 1'b1; hd = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (btn_release) begin seen = 1'b1; sh = btn_short; hd = btn_held; break; end
      end
      check("release after long", seen, 1'b1);
      check("short after long", sh, 1'b0);
      check("held at release", hd, 1'b0);
      repeat (5) tick();

      // Reset while pressed, pin kept low
      btn_in = 1'b0;
      seen = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (btn_press) begin seen = 1'b1; break; end
      end
      check("press before reset", seen, 1'b1);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      check("rst level", btn_level, 1'b0);
      check("rst press", btn_press, 1'b0);
      check("rst release", btn_release, 1'b0);
      check("rst short", btn_short, 1'b0);
      rst = 1'b0;
      lat = -1; rel_cnt = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         rel_cnt += int'(btn_release) + int'(btn_short);
         if (btn_press) begin lat = i; break; end
      end
      check_int("press after reset", lat, SYNC + DebN);
      check_int("release or short after reset", rel_cnt, 0);
      btn_in = 1'b1;
      repeat (20) tick();

      // Random bursts with occasional resets
      for (int b = 0; b < 300; b++) begin
         rst = ($urandom_range(0, 29) == 0);
         btn_in = $urandom_range(0, 1);
         cnt = rst ? $urandom_range(1, 3) : $urandom_range(1, 60);
         repeat (cnt) tick();
      end
      rst = 1'b0; btn_in = 1'b1;
      repeat (20) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
